// File: rtl/audio_pkg.sv
// Shared types and constants for the audio DAC serializer.
package audio_pkg;

    // Serializer control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_e;

    // Serial format select values.
    localparam logic MODE_I2S = 1'b0;
    localparam logic MODE_LJ  = 1'b1;

    // Flops in each codec-clock synchroniser chain.
    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO holding packed {left, right} stereo frames.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module sample_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags and qualified push/pop strobes, all derived from the registered level.
    always_comb begin
        full      = (level_r == LW'(DEPTH));
        empty     = (level_r == {LW{1'b0}});
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        rd_data   = mem_r[rd_ptr_r];
        level     = level_r;
    end

    // Frame storage; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/audio_dac_serializer.sv
// Stereo PCM serializer driving AUD_DACDAT from codec-sourced BCLK/LRCK,
// with a frame FIFO, configurable sample width and I2S/left-justified modes.
module audio_dac_serializer
    import audio_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              Clk,
    input  logic                              Reset,
    input  logic                              en,
    input  logic                              mode,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_W-1:0]                 in_left,
    input  logic [DATA_W-1:0]                 in_right,
    input  logic                              AUD_BCLK,
    input  logic                              AUD_DACLRCK,
    output logic                              AUD_DACDAT,
    output logic                              data_over,
    output logic                              underrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    // Counter must reach DATA_W+1 so that I2S can address its last bit and then pad.
    localparam int                CNT_W    = $clog2(DATA_W + 2);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DATA_W + 1);
    localparam logic [DATA_W-1:0] MSB_MASK = {1'b1, {(DATA_W-1){1'b0}}};

    logic [SYNC_STAGES-1:0] bclk_sync_r;
    logic [SYNC_STAGES-1:0] lrck_sync_r;
    logic                   bclk_prev_r;
    logic                   lr_q_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   mode_r;
    state_e                 state_r;
    logic [DATA_W-1:0]      hold_left_r;
    logic [DATA_W-1:0]      hold_right_r;
    logic                   prev_popped_r;

    logic                   bclk_s;
    logic                   lrck_s;
    logic                   bfall_s;
    logic                   slot_start_s;
    logic                   left_start_s;
    logic [CNT_W-1:0]       cnt_next_s;
    logic                   mode_eff_s;
    logic                   fetch_s;
    logic                   pop_s;
    logic                   full_s;
    logic                   empty_s;
    logic [2*DATA_W-1:0]    head_s;
    logic [DATA_W-1:0]      fetch_left_s;
    logic [DATA_W-1:0]      fetch_right_s;
    logic [DATA_W-1:0]      word_s;
    logic                   bit_s;

    sample_fifo #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (Clk),
        .reset   (Reset),
        .push    (in_valid),
        .pop     (pop_s),
        .wr_data ({in_left, in_right}),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (fifo_level)
    );

    // Ready depends only on the registered FIFO level, never on this cycle's pop.
    assign in_ready = !full_s;

    // Bring the asynchronous codec clocks into the Clk domain and keep BCLK history for edge detect.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bclk_sync_r <= {SYNC_STAGES{1'b0}};
            lrck_sync_r <= {SYNC_STAGES{1'b0}};
            bclk_prev_r <= 1'b0;
        end else begin
            bclk_sync_r <= {bclk_sync_r[SYNC_STAGES-2:0], AUD_BCLK};
            lrck_sync_r <= {lrck_sync_r[SYNC_STAGES-2:0], AUD_DACLRCK};
            bclk_prev_r <= bclk_sync_r[SYNC_STAGES-1];
        end
    end

    // Edge/slot decode, frame fetch selection and the serial bit for the current BCLK edge.
    always_comb begin
        bclk_s       = bclk_sync_r[SYNC_STAGES-1];
        lrck_s       = lrck_sync_r[SYNC_STAGES-1];
        bfall_s      = bclk_prev_r && !bclk_s;
        slot_start_s = bfall_s && (lrck_s != lr_q_r);
        left_start_s = slot_start_s && !lrck_s;

        if (slot_start_s) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_MAX) begin
            cnt_next_s = cnt_r;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end

        // A new mode applies from the slot that starts on this very edge.
        mode_eff_s = slot_start_s ? mode : mode_r;

        fetch_s = left_start_s && en && ((state_r == SYNC) || (state_r == RUN));
        pop_s   = fetch_s && !empty_s;

        // An empty FIFO at fetch time mutes the whole frame.
        if (empty_s) begin
            fetch_left_s  = {DATA_W{1'b0}};
            fetch_right_s = {DATA_W{1'b0}};
        end else begin
            fetch_left_s  = head_s[2*DATA_W-1:DATA_W];
            fetch_right_s = head_s[DATA_W-1:0];
        end

        // The left slot's first bit comes from the frame being fetched on the same edge.
        if (left_start_s) begin
            word_s = fetch_left_s;
        end else if (lrck_s) begin
            word_s = hold_right_r;
        end else begin
            word_s = hold_left_r;
        end

        // Shifting left past the word width yields zero, which gives the slot padding for free.
        if (mode_eff_s == MODE_LJ) begin
            bit_s = |((word_s << cnt_next_s) & MSB_MASK);
        end else if (cnt_next_s == {CNT_W{1'b0}}) begin
            bit_s = 1'b0;
        end else begin
            bit_s = |((word_s << (cnt_next_s - CNT_W'(1))) & MSB_MASK);
        end
    end

    // Slot tracking: previous LRCK level, bit position within the slot and latched mode.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            lr_q_r <= 1'b0;
            cnt_r  <= {CNT_W{1'b0}};
            mode_r <= MODE_I2S;
        end else if (bfall_s) begin
            lr_q_r <= lrck_s;
            cnt_r  <= cnt_next_s;
            if (slot_start_s) begin
                mode_r <= mode;
            end
        end
    end

    // Control FSM, frame hold registers, serial output and status pulses.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r       <= IDLE;
            AUD_DACDAT    <= 1'b0;
            data_over     <= 1'b0;
            underrun      <= 1'b0;
            hold_left_r   <= {DATA_W{1'b0}};
            hold_right_r  <= {DATA_W{1'b0}};
            prev_popped_r <= 1'b0;
        end else begin
            data_over <= 1'b0;
            underrun  <= 1'b0;

            if (fetch_s) begin
                hold_left_r   <= fetch_left_s;
                hold_right_r  <= fetch_right_s;
                underrun      <= empty_s;
                prev_popped_r <= !empty_s;
            end

            case (state_r)
                IDLE: begin
                    AUD_DACDAT <= 1'b0;
                    if (en) begin
                        state_r <= SYNC;
                    end
                end
                SYNC: begin
                    if (!en) begin
                        state_r    <= IDLE;
                        AUD_DACDAT <= 1'b0;
                    end else if (left_start_s) begin
                        state_r    <= RUN;
                        AUD_DACDAT <= bit_s;
                    end else begin
                        AUD_DACDAT <= 1'b0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state_r    <= IDLE;
                        AUD_DACDAT <= 1'b0;
                    end else if (bfall_s) begin
                        AUD_DACDAT <= bit_s;
                        if (left_start_s) begin
                            data_over <= prev_popped_r;
                        end
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    AUD_DACDAT <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Self-checking bench for audio_dac_serializer: a codec-side BCLK/LRCK generator
// that also acts as the DAC, sampling AUD_DACDAT on each BCLK rising edge and
// comparing against a frame-level model of what each slot should carry.
`timescale 1ns/1ps
module tb_audio_dac_serializer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          en;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_left;
    logic [DW-1:0] in_right;
    logic          AUD_BCLK;
    logic          AUD_DACLRCK;
    logic          AUD_DACDAT;
    logic          data_over;
    logic          underrun;
    logic [2:0]    fifo_level;

    audio_dac_serializer #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .en          (en),
        .mode        (mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_left     (in_left),
        .in_right    (in_right),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .data_over   (data_over),
        .underrun    (underrun),
        .fifo_level  (fifo_level)
    );

    always #5 Clk = ~Clk;

    // Scoreboard / model state
    int            n_vec = 0;
    int            n_err = 0;
    logic [31:0]   m_q[$];
    logic [DW-1:0] m_hl = '0;
    logic [DW-1:0] m_hr = '0;
    bit            m_run = 1'b0;
    bit            m_prev_pop = 1'b0;
    logic          m_mode = 1'b0;
    int            k = 0;
    int            bcnt = 0;
    int            exp_over = 0;
    int            exp_under = 0;
    int            act_over = 0;
    int            act_under = 0;
    bit            chk_on = 1'b0;
    event          bfall_ev;
    event          lr_fall_ev;

    typedef struct {
        logic          valid;
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          exp_ready;
        int            exp_level;
    } vec_t;
    vec_t tbl[6];

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Bit the DAC should see at bit index kk of a slot carrying word w.
    function automatic logic exp_bit(input logic [DW-1:0] w, input int kk, input logic lj);
        logic b;
        if (lj) b = (kk < DW) ? w[DW-1-kk] : 1'b0;
        else    b = (kk >= 1 && kk <= DW) ? w[DW-kk] : 1'b0;
        return b;
    endfunction

    // Codec clock generator plus DAC-side sampling and frame-level model.
    initial begin
        logic eb;
        AUD_BCLK = 1'b0;
        AUD_DACLRCK = 1'b0;
        forever begin
            repeat (4) @(negedge Clk);
            AUD_BCLK = 1'b1;
            if (chk_on && !Reset) begin
                eb = m_run ? exp_bit(AUD_DACLRCK ? m_hr : m_hl, k, m_mode) : 1'b0;
                check_int($sformatf("dacdat_bit lr=%0b k=%0d", AUD_DACLRCK, k), int'(AUD_DACDAT), int'(eb));
            end
            repeat (4) @(negedge Clk);
            AUD_BCLK = 1'b0;
            bcnt++;
            if (bcnt == 32) begin
                bcnt = 0;
                AUD_DACLRCK = ~AUD_DACLRCK;
                k = 0;
                m_mode = mode;
                if (!AUD_DACLRCK) begin
                    if (en && !Reset) begin
                        if (m_run && m_prev_pop) exp_over++;
                        if (m_q.size() > 0) begin
                            {m_hl, m_hr} = m_q.pop_front();
                            m_prev_pop = 1'b1;
                        end else begin
                            m_hl = '0;
                            m_hr = '0;
                            m_prev_pop = 1'b0;
                            exp_under++;
                        end
                        m_run = 1'b1;
                    end
                    -> lr_fall_ev;
                end
            end else if (k < 1000) begin
                k++;
            end
            -> bfall_ev;
        end
    end

    // Count every Clk cycle a status pulse is high (a stretched pulse counts more than once).
    always @(negedge Clk) begin
        if (data_over === 1'b1) act_over <= act_over + 1;
        if (underrun === 1'b1)  act_under <= act_under + 1;
    end

    // Move to one Clk after the BCLK fall where bit index kk is reached (optionally in a left slot).
    task automatic wait_k(input int kk, input bit need_left);
        do @(bfall_ev); while (!(k == kk && (!need_left || !AUD_DACLRCK)));
        @(negedge Clk);
    endtask

    task automatic set_en(input logic v);
        en = v;
        if (!v) m_run = 1'b0;
    endtask

    task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        @(negedge Clk);
        in_valid = 1'b0;
        if (m_q.size() < DEPTH) m_q.push_back({l, r});
        check_int("push_level", int'(fifo_level), m_q.size());
        check_int("push_ready", int'(in_ready), int'(m_q.size() != DEPTH));
    endtask

    task automatic check_counts(input string tag);
        check_int({tag, "_data_over_count"}, act_over, exp_over);
        check_int({tag, "_underrun_count"}, act_under, exp_under);
    endtask

    // Push nfr frames with en low, play them plus two extra frames, then stop.
    task automatic play(input logic md, input int nfr, input bit fixed_first);
        mode = md;
        for (int i = 0; i < nfr; i++) begin
            if (fixed_first && i == 0) push_frame(16'hA5C3, 16'h0F0F);
            else push_frame(DW'($urandom), DW'($urandom));
        end
        wait_k(10, 1'b0);
        set_en(1'b1);
        repeat (nfr + 2) @(lr_fall_ev);
        wait_k(10, 1'b0);
        set_en(1'b0);
        @(negedge Clk);
        check_counts(md ? "lj" : "i2s");
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; en = 1'b0; mode = 1'b0; in_valid = 1'b0;
        in_left = '0; in_right = '0;

        // FIFO fill vectors with en low: the 5th offer must be refused.
        for (int i = 0; i < 6; i++) begin
            tbl[i].valid     = (i < 5);
            tbl[i].l         = DW'($urandom);
            tbl[i].r         = DW'($urandom);
            tbl[i].exp_level = (i < 4) ? i + 1 : 4;
            tbl[i].exp_ready = (i < 3);
        end
        tbl[0].l = 16'hA5C3;
        tbl[0].r = 16'h0F0F;

        repeat (3) @(negedge Clk);
        check_int("rst_dacdat", int'(AUD_DACDAT), 0);
        check_int("rst_ready", int'(in_ready), 1);
        check_int("rst_level", int'(fifo_level), 0);
        check_int("rst_data_over", int'(data_over), 0);
        check_int("rst_underrun", int'(underrun), 0);
        Reset = 1'b0;
        chk_on = 1'b1;

        for (int i = 0; i < 6; i++) begin
            in_valid = tbl[i].valid;
            in_left  = tbl[i].l;
            in_right = tbl[i].r;
            @(negedge Clk);
            if (tbl[i].valid && m_q.size() < DEPTH) m_q.push_back({tbl[i].l, tbl[i].r});
            check_int($sformatf("fill_level[%0d]", i), int'(fifo_level), tbl[i].exp_level);
            check_int($sformatf("fill_ready[%0d]", i), int'(in_ready), int'(tbl[i].exp_ready));
        end
        in_valid = 1'b0;

        // Left-justified playback of the queued frames, with exact output latency at the first left slot.
        mode = 1'b1;
        wait_k(10, 1'b0);
        set_en(1'b1);
        @(lr_fall_ev);
        repeat (2) @(negedge Clk);
        check_int("lj_first_bit_before_latency", int'(AUD_DACDAT), 0);
        @(negedge Clk);
        check_int("lj_first_bit_after_latency", int'(AUD_DACDAT), 1);
        @(negedge Clk);
        check_int("after_pop_level", int'(fifo_level), 3);
        check_int("after_pop_ready", int'(in_ready), 1);
        repeat (4) @(lr_fall_ev);
        wait_k(10, 1'b0);
        set_en(1'b0);
        @(negedge Clk);
        check_counts("lj_fill");
        check_int("lj_fill_data_over_abs", act_over, 4);
        check_int("lj_fill_underrun_abs", act_under, 1);

        // I2S with the same leading frame, then an empty-FIFO run, then random runs.
        play(1'b0, 3, 1'b1);
        play(1'b1, 0, 1'b0);
        for (int it = 0; it < 3; it++) begin
            play(1'($urandom_range(0, 1)), $urandom_range(0, 4), 1'b0);
        end

        // Reset in the middle of a left slot with en held high.
        mode = 1'b1;
        push_frame(DW'($urandom), DW'($urandom));
        push_frame(DW'($urandom), DW'($urandom));
        wait_k(10, 1'b0);
        set_en(1'b1);
        @(lr_fall_ev);
        wait_k(10, 1'b1);
        Reset = 1'b1;
        m_run = 1'b0;
        m_prev_pop = 1'b0;
        m_q.delete();
        @(negedge Clk);
        check_int("midreset_dacdat", int'(AUD_DACDAT), 0);
        check_int("midreset_level", int'(fifo_level), 0);
        check_int("midreset_ready", int'(in_ready), 1);
        @(negedge Clk);
        Reset = 1'b0;
        push_frame(DW'($urandom), DW'($urandom));
        repeat (2) @(lr_fall_ev);
        wait_k(10, 1'b0);
        set_en(1'b0);
        @(negedge Clk);
        check_counts("midreset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
